// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_rr_arbiter
// Brief    : Round-robin arbiter sharing one single-outstanding OBI subordinate
//            between NUM_MGR OBI managers.
// Revision : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter #(
  parameter int unsigned NUM_MGR    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [NUM_MGR-1:0]               mgr_req_i,
  output logic [NUM_MGR-1:0]               mgr_gnt_o,
  input  logic [NUM_MGR*ADDR_WIDTH-1:0]    mgr_addr_i,
  input  logic [NUM_MGR-1:0]               mgr_we_i,
  input  logic [NUM_MGR*DATA_WIDTH/8-1:0]  mgr_be_i,
  input  logic [NUM_MGR*DATA_WIDTH-1:0]    mgr_wdata_i,
  output logic [NUM_MGR-1:0]               mgr_rvalid_o,
  input  logic [NUM_MGR-1:0]               mgr_rready_i,
  output logic [DATA_WIDTH-1:0]            mgr_rdata_o,
  output logic                             mgr_err_o,
  output logic                             sbr_req_o,
  input  logic                             sbr_gnt_i,
  output logic [ADDR_WIDTH-1:0]            sbr_addr_o,
  output logic                             sbr_we_o,
  output logic [DATA_WIDTH/8-1:0]          sbr_be_o,
  output logic [DATA_WIDTH-1:0]            sbr_wdata_o,
  input  logic                             sbr_rvalid_i,
  output logic                             sbr_rready_o,
  input  logic [DATA_WIDTH-1:0]            sbr_rdata_i,
  input  logic                             sbr_err_i
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;

  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_addr = 2'd1;
  localparam logic [1:0] c_state_resp = 2'd2;

  localparam logic [IDX_WIDTH-1:0] c_last_reset = IDX_WIDTH'(NUM_MGR - 1);

  if (NUM_MGR < 2 || NUM_MGR > 8) begin : g_num_mgr_check
    $error("obi_rr_arbiter: NUM_MGR must lie in 2..8");
  end

  logic [1:0]           r_state;
  logic [IDX_WIDTH-1:0] r_owner;
  logic [IDX_WIDTH-1:0] r_last;

  logic                 w_any_req;
  logic [IDX_WIDTH-1:0] w_winner;
  logic [IDX_WIDTH-1:0] w_sel;
  logic                 w_fwd;
  logic                 w_resp;
  int                   w_idx;

  // Scan from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    w_any_req = |mgr_req_i;
    w_winner  = r_last;
    w_idx     = 0;
    for (int i = NUM_MGR; i >= 1; i--) begin
      w_idx = int'(r_last) + i;
      if (w_idx >= int'(NUM_MGR)) begin
        w_idx = w_idx - int'(NUM_MGR);
      end
      if (mgr_req_i[IDX_WIDTH'(w_idx)]) begin
        w_winner = IDX_WIDTH'(w_idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= c_state_idle;
      r_owner <= '0;
      r_last  <= c_last_reset;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            if (sbr_gnt_i) begin
              r_last  <= w_winner;
              r_state <= c_state_resp;
            end else begin
              r_state <= c_state_addr;
            end
          end
        end
        c_state_addr: begin
          if (sbr_gnt_i) begin
            r_last  <= r_owner;
            r_state <= c_state_resp;
          end
        end
        c_state_resp: begin
          if (sbr_rvalid_i && mgr_rready_i[r_owner]) begin
            r_state <= c_state_idle;
          end
        end
        default: r_state <= c_state_idle;
      endcase
    end
  end

  // Once locked in ADDR the owner is held even if it drops its request.
  always_comb begin
    w_sel  = (r_state == c_state_addr) ? r_owner : w_winner;
    w_fwd  = ((r_state == c_state_idle) && w_any_req) || (r_state == c_state_addr);
    w_resp = (r_state == c_state_resp);

    sbr_req_o    = w_fwd;
    sbr_addr_o   = '0;
    sbr_we_o     = 1'b0;
    sbr_be_o     = '0;
    sbr_wdata_o  = '0;
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    sbr_rready_o = 1'b0;
    mgr_rdata_o  = '0;
    mgr_err_o    = 1'b0;

    if (w_fwd) begin
      sbr_addr_o       = mgr_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
      sbr_we_o         = mgr_we_i[w_sel];
      sbr_be_o         = mgr_be_i[int'(w_sel)*BE_WIDTH +: BE_WIDTH];
      sbr_wdata_o      = mgr_wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
      mgr_gnt_o[w_sel] = sbr_gnt_i;
    end

    if (w_resp) begin
      mgr_rvalid_o[r_owner] = sbr_rvalid_i;
      sbr_rready_o          = mgr_rready_i[r_owner];
      mgr_rdata_o           = sbr_rdata_i;
      mgr_err_o             = sbr_err_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_rr_arbiter
// Brief    : Self-checking bench for obi_rr_arbiter with a round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

  localparam int N     = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int N_TXN = 60;
  localparam int OUT_W = 2*N + 2*DW + AW + BW + 4;
  localparam int FWD_W = 1 + AW + 1 + BW + DW + N;
  localparam int RSP_W = 1 + N + N + 1 + DW + 1;

  logic            clk_i = 1'b0;
  logic            reset_ni = 1'b0;
  logic [N-1:0]    mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_rvalid_o, mgr_rready_i;
  logic [N*AW-1:0] mgr_addr_i;
  logic [N*BW-1:0] mgr_be_i;
  logic [N*DW-1:0] mgr_wdata_i;
  logic [DW-1:0]   mgr_rdata_o;
  logic            mgr_err_o;
  logic            sbr_req_o, sbr_gnt_i, sbr_we_o, sbr_rvalid_i, sbr_rready_o, sbr_err_i;
  logic [AW-1:0]   sbr_addr_o;
  logic [BW-1:0]   sbr_be_o;
  logic [DW-1:0]   sbr_wdata_o, sbr_rdata_i;

  logic [AW-1:0]   a_addr  [N];
  logic            a_we    [N];
  logic [BW-1:0]   a_be    [N];
  logic [DW-1:0]   a_wdata [N];

  int n_cmp  = 0;
  int n_fail = 0;
  int last_m = N - 1;

  logic [OUT_W-1:0] all_outs;
  logic [FWD_W-1:0] fwd_obs;
  logic [RSP_W-1:0] resp_obs;

  assign all_outs = {mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o, sbr_req_o,
                     sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, sbr_rready_o};
  assign fwd_obs  = {sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, mgr_gnt_o};
  assign resp_obs = {sbr_req_o, mgr_gnt_o, mgr_rvalid_o, sbr_rready_o, mgr_rdata_o, mgr_err_o};

  always #5 clk_i = ~clk_i;

  obi_rr_arbiter #(.NUM_MGR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .mgr_req_i   (mgr_req_i),
    .mgr_gnt_o   (mgr_gnt_o),
    .mgr_addr_i  (mgr_addr_i),
    .mgr_we_i    (mgr_we_i),
    .mgr_be_i    (mgr_be_i),
    .mgr_wdata_i (mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o),
    .mgr_rready_i(mgr_rready_i),
    .mgr_rdata_o (mgr_rdata_o),
    .mgr_err_o   (mgr_err_o),
    .sbr_req_o   (sbr_req_o),
    .sbr_gnt_i   (sbr_gnt_i),
    .sbr_addr_o  (sbr_addr_o),
    .sbr_we_o    (sbr_we_o),
    .sbr_be_o    (sbr_be_o),
    .sbr_wdata_o (sbr_wdata_o),
    .sbr_rvalid_i(sbr_rvalid_i),
    .sbr_rready_o(sbr_rready_o),
    .sbr_rdata_i (sbr_rdata_i),
    .sbr_err_i   (sbr_err_i)
  );

  // Reference: first requester after the last granted one, modulo N.
  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic apply_mgr();
    for (int k = 0; k < N; k++) begin
      mgr_addr_i[k*AW +: AW]  = a_addr[k];
      mgr_we_i[k]             = a_we[k];
      mgr_be_i[k*BW +: BW]    = a_be[k];
      mgr_wdata_i[k*DW +: DW] = a_wdata[k];
    end
  endtask

  task automatic rand_mgr(input int k);
    a_addr[k]  = $urandom;
    a_we[k]    = 1'($urandom_range(0, 1));
    a_be[k]    = BW'($urandom);
    a_wdata[k] = $urandom;
  endtask

  task automatic clear_inputs();
    mgr_req_i = '0; mgr_rready_i = '0;
    sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_rdata_i = '0; sbr_err_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_addr[k] = '0; a_we[k] = 1'b0; a_be[k] = '0; a_wdata[k] = '0;
    end
    apply_mgr();
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_ni = 1'b0;
    tick();
    tick();
    reset_ni = 1'b1;
    last_m   = N - 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_ni = 1'b0;
    #2;
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_idle: got %h expected 0", all_outs);
    end
    sbr_rvalid_i = 1'b1; sbr_err_i = 1'b1; sbr_rdata_i = '1; mgr_rready_i = '1;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_busy_inputs: got %h expected 0", all_outs);
    end
    tick(); tick();
    clear_inputs();
    reset_ni = 1'b1;
    last_m   = N - 1;
    settle();
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h expected 0", all_outs);
    end
    tick();
  endtask

  task automatic test_single_write();
    clear_inputs();
    a_addr[0] = 32'h10; a_we[0] = 1'b1; a_be[0] = 4'hF; a_wdata[0] = 32'hDEADBEEF;
    apply_mgr();
    mgr_req_i = 3'b001; sbr_gnt_i = 1'b1;
    settle();
    n_cmp++;
    if (fwd_obs !== {1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'b001}) begin
      n_fail++; $display("FAIL single_fwd: got %h expected %h", fwd_obs,
                         {1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'b001});
    end
    tick();
    mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = 3'b001;
    settle();
    n_cmp++;
    if (resp_obs !== {1'b0, 3'b000, 3'b001, 1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: got %h expected %h", resp_obs,
                         {1'b0, 3'b000, 3'b001, 1'b1, 32'h0, 1'b0});
    end
    tick();
    clear_inputs();
    last_m = 0;
  endtask

  // Manager 0 is locked while manager 1 (now higher priority) arrives mid-stall.
  task automatic test_grant_stall();
    logic [FWD_W-1:0] exp_f;
    logic [RSP_W-1:0] exp_r;
    clear_inputs();
    a_addr[0] = 32'hA000_0000; a_we[0] = 1'b0; a_be[0] = 4'hF; a_wdata[0] = 32'h0;
    a_addr[1] = 32'hB000_0004; a_we[1] = 1'b1; a_be[1] = 4'h3; a_wdata[1] = 32'h1234_5678;
    apply_mgr();
    mgr_req_i = 3'b001;
    for (int c = 0; c < 4; c++) begin
      sbr_gnt_i = (c == 3);
      if (c == 1) mgr_req_i = 3'b011;
      settle();
      exp_f = {1'b1, a_addr[0], a_we[0], a_be[0], a_wdata[0], (c == 3) ? 3'b001 : 3'b000};
      n_cmp++;
      if (fwd_obs !== exp_f) begin
        n_fail++; $display("FAIL stall_fwd c=%0d: got %h expected %h", c, fwd_obs, exp_f);
      end
      tick();
    end
    mgr_req_i = 3'b010; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = '1;
    sbr_rdata_i = 32'h5;
    settle();
    exp_r = {1'b0, 3'b000, 3'b001, 1'b1, 32'h5, 1'b0};
    n_cmp++;
    if (resp_obs !== exp_r) begin
      n_fail++; $display("FAIL stall_resp: got %h expected %h", resp_obs, exp_r);
    end
    tick();
    sbr_rvalid_i = 1'b0; sbr_gnt_i = 1'b1;
    settle();
    exp_f = {1'b1, a_addr[1], a_we[1], a_be[1], a_wdata[1], 3'b010};
    n_cmp++;
    if (fwd_obs !== exp_f) begin
      n_fail++; $display("FAIL stall_next_mgr1: got %h expected %h", fwd_obs, exp_f);
    end
    tick();
    mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = 3'b010;
    settle();
    exp_r = {1'b0, 3'b000, 3'b010, 1'b1, 32'h5, 1'b0};
    n_cmp++;
    if (resp_obs !== exp_r) begin
      n_fail++; $display("FAIL stall_resp_mgr1: got %h expected %h", resp_obs, exp_r);
    end
    tick();
    clear_inputs();
    last_m = 1;
  endtask

  task automatic test_contention();
    int ord [4] = '{0, 1, 0, 1};
    logic [FWD_W-1:0] exp_f;
    logic [RSP_W-1:0] exp_r;
    do_reset();
    for (int k = 0; k < N; k++) begin
      a_addr[k] = 32'h100 * k + 32'h8; a_we[k] = k[0]; a_be[k] = BW'(k + 1);
      a_wdata[k] = 32'h5A00 + k;
    end
    apply_mgr();
    mgr_req_i = 3'b011;
    for (int t = 0; t < 4; t++) begin
      sbr_gnt_i = 1'b1; sbr_rvalid_i = 1'b0;
      settle();
      exp_f = {1'b1, a_addr[ord[t]], a_we[ord[t]], a_be[ord[t]], a_wdata[ord[t]], onehot(ord[t])};
      n_cmp++;
      if (fwd_obs !== exp_f) begin
        n_fail++; $display("FAIL contention_grant t=%0d: got %h expected %h", t, fwd_obs, exp_f);
      end
      tick();
      sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = '1; sbr_rdata_i = DW'(t);
      settle();
      exp_r = {1'b0, 3'b000, onehot(ord[t]), 1'b1, DW'(t), 1'b0};
      n_cmp++;
      if (resp_obs !== exp_r) begin
        n_fail++; $display("FAIL contention_resp t=%0d: got %h expected %h", t, resp_obs, exp_r);
      end
      tick();
    end
    clear_inputs();
    last_m = 1;
  endtask

  task automatic test_backpressure();
    logic [FWD_W-1:0] exp_f;
    logic [RSP_W-1:0] exp_r;
    clear_inputs();
    a_addr[0] = 32'h04; a_we[0] = 1'b0; a_be[0] = 4'hF;
    a_addr[1] = 32'h44; a_we[1] = 1'b1; a_be[1] = 4'h1; a_wdata[1] = 32'h99;
    apply_mgr();
    mgr_req_i = 3'b001; sbr_gnt_i = 1'b1;
    settle();
    exp_f = {1'b1, 32'h04, 1'b0, 4'hF, 32'h0, 3'b001};
    n_cmp++;
    if (fwd_obs !== exp_f) begin
      n_fail++; $display("FAIL bp_grant: got %h expected %h", fwd_obs, exp_f);
    end
    tick();
    mgr_req_i = 3'b010; sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'hCAFEF00D;
    mgr_rready_i = 3'b110;
    for (int c = 0; c < 5; c++) begin
      settle();
      exp_r = {1'b0, 3'b000, 3'b001, 1'b0, 32'hCAFEF00D, 1'b0};
      n_cmp++;
      if (resp_obs !== exp_r) begin
        n_fail++; $display("FAIL bp_hold c=%0d: got %h expected %h", c, resp_obs, exp_r);
      end
      tick();
    end
    mgr_rready_i = 3'b111;
    settle();
    exp_r = {1'b0, 3'b000, 3'b001, 1'b1, 32'hCAFEF00D, 1'b0};
    n_cmp++;
    if (resp_obs !== exp_r) begin
      n_fail++; $display("FAIL bp_release: got %h expected %h", resp_obs, exp_r);
    end
    tick();
    sbr_rvalid_i = 1'b0;
    settle();
    exp_f = {1'b1, 32'h44, 1'b1, 4'h1, 32'h99, 3'b010};
    n_cmp++;
    if (fwd_obs !== exp_f) begin
      n_fail++; $display("FAIL bp_next_grant: got %h expected %h", fwd_obs, exp_f);
    end
    tick();
    mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = 3'b010;
    tick();
    clear_inputs();
    last_m = 1;
  endtask

  task automatic test_error();
    logic [FWD_W-1:0] exp_f;
    logic [RSP_W-1:0] exp_r;
    clear_inputs();
    sbr_err_i = 1'b1; sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'hFFFF_0000;
    settle();
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL err_idle_quiet: got %h expected 0", all_outs);
    end
    tick();
    a_addr[2] = 32'h20; a_we[2] = 1'b0; a_be[2] = 4'hC; apply_mgr();
    sbr_err_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_rdata_i = '0;
    mgr_req_i = 3'b100; sbr_gnt_i = 1'b1;
    settle();
    exp_f = {1'b1, 32'h20, 1'b0, 4'hC, 32'h0, 3'b100};
    n_cmp++;
    if (fwd_obs !== exp_f) begin
      n_fail++; $display("FAIL err_grant: got %h expected %h", fwd_obs, exp_f);
    end
    tick();
    mgr_req_i = '0; sbr_gnt_i = 1'b0; mgr_rready_i = 3'b100;
    settle();
    exp_r = {1'b0, 3'b000, 3'b000, 1'b1, 32'h0, 1'b0};
    n_cmp++;
    if (resp_obs !== exp_r) begin
      n_fail++; $display("FAIL err_wait: got %h expected %h", resp_obs, exp_r);
    end
    tick();
    sbr_rvalid_i = 1'b1; sbr_err_i = 1'b1;
    settle();
    exp_r = {1'b0, 3'b000, 3'b100, 1'b1, 32'h0, 1'b1};
    n_cmp++;
    if (resp_obs !== exp_r) begin
      n_fail++; $display("FAIL err_resp: got %h expected %h", resp_obs, exp_r);
    end
    tick();
    sbr_rvalid_i = 1'b0;
    settle();
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL err_after: got %h expected 0", all_outs);
    end
    tick();
    clear_inputs();
    last_m = 2;
  endtask

  task automatic test_reset_mid_resp();
    logic [FWD_W-1:0] exp_f;
    clear_inputs();
    a_addr[1] = 32'h30; apply_mgr();
    mgr_req_i = 3'b010; sbr_gnt_i = 1'b1;
    tick();
    mgr_req_i = '0; sbr_gnt_i = 1'b0; mgr_rready_i = 3'b010;
    settle();
    sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'h77; sbr_err_i = 1'b1;
    reset_ni = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_mid_resp: got %h expected 0", all_outs);
    end
    tick(); tick();
    clear_inputs();
    reset_ni = 1'b1;
    last_m = N - 1;
    for (int k = 0; k < N; k++) a_addr[k] = 32'h1000 + 32'(k);
    apply_mgr();
    mgr_req_i = 3'b111; sbr_gnt_i = 1'b1;
    settle();
    exp_f = {1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 3'b001};
    n_cmp++;
    if (fwd_obs !== exp_f) begin
      n_fail++; $display("FAIL reset_then_mgr0: got %h expected %h", fwd_obs, exp_f);
    end
    tick();
    mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; mgr_rready_i = 3'b001;
    tick();
    clear_inputs();
    last_m = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < N_TXN; t++) begin
      int e, gd, rd;
      logic [N-1:0] req;
      logic hs;
      logic [FWD_W-1:0] exp_f;
      logic [RSP_W-1:0] exp_r;
      for (int k = 0; k < N; k++) rand_mgr(k);
      apply_mgr();
      req = N'($urandom_range(1, (1 << N) - 1));
      mgr_req_i = req; sbr_rvalid_i = 1'b0; mgr_rready_i = N'($urandom);
      e  = rr_pick(last_m, req);
      gd = $urandom_range(0, 3);
      for (int c = 0; c <= gd; c++) begin
        sbr_gnt_i = (c == gd);
        if (c > 0) begin
          for (int k = 0; k < N; k++) if (k != e) rand_mgr(k);
          apply_mgr();
          mgr_req_i = N'($urandom) | onehot(e);
        end
        settle();
        exp_f = {1'b1, a_addr[e], a_we[e], a_be[e], a_wdata[e],
                 (c == gd) ? onehot(e) : {N{1'b0}}};
        n_cmp++;
        if (fwd_obs !== exp_f) begin
          n_fail++; $display("FAIL rand_fwd t=%0d c=%0d: got %h expected %h", t, c, fwd_obs, exp_f);
        end
        tick();
      end
      last_m = e;
      rd = $urandom_range(0, 3);
      hs = 1'b0;
      for (int c = 0; c < rd + 4 && !hs; c++) begin
        logic [N-1:0]  rdy;
        logic [DW-1:0] rdat;
        logic          rerr, rv;
        rv   = (c >= rd);
        rdy  = N'($urandom);
        if (c >= rd + 2) rdy[e] = 1'b1;
        rdat = $urandom;
        rerr = 1'($urandom_range(0, 1));
        mgr_req_i = N'($urandom); sbr_gnt_i = 1'($urandom_range(0, 1));
        sbr_rvalid_i = rv; mgr_rready_i = rdy; sbr_rdata_i = rdat; sbr_err_i = rerr;
        settle();
        exp_r = {1'b0, {N{1'b0}}, rv ? onehot(e) : {N{1'b0}}, rdy[e], rdat, rerr};
        n_cmp++;
        if (resp_obs !== exp_r) begin
          n_fail++; $display("FAIL rand_resp t=%0d c=%0d: got %h expected %h", t, c, resp_obs, exp_r);
        end
        hs = rv && rdy[e];
        tick();
      end
      sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_err_i = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_grant_stall();
    test_contention();
    test_backpressure();
    test_error();
    test_reset_mid_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Round-robin arbiter that shares one OBI subordinate between NUM_MGR OBI managers. The subordinate is typically a byte-enabled SRAM slave or an equivalent single-outstanding peripheral.
- Allows exactly one transaction in flight: address phase, then response phase, then release.
- Routes the response back to the owning manager and keeps address-phase signals stable until grant, as OBI requires.

Parameters:
- NUM_MGR, 2, number of managers (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- mgr_req_i  in  NUM_MGR  per-manager request.
- mgr_gnt_o  out  NUM_MGR  per-manager grant.
- mgr_addr_i  in  NUM_MGR*ADDR_WIDTH  packed addresses; manager k at slice k.
- mgr_we_i  in  NUM_MGR  write enables.
- mgr_be_i  in  NUM_MGR*DATA_WIDTH/8  byte enables.
- mgr_wdata_i  in  NUM_MGR*DATA_WIDTH  write data.
- mgr_rvalid_o  out  NUM_MGR  per-manager response valid.
- mgr_rready_i  in  NUM_MGR  per-manager response ready.
- mgr_rdata_o  out  DATA_WIDTH  response data, broadcast to all managers.
- mgr_err_o  out  1  response error, broadcast to all managers.
- sbr_req_o  out  1  subordinate request.
- sbr_gnt_i  in  1  subordinate grant.
- sbr_addr_o  out  ADDR_WIDTH  subordinate address.
- sbr_we_o  out  1  subordinate write enable.
- sbr_be_o  out  DATA_WIDTH/8  subordinate byte enable.
- sbr_wdata_o  out  DATA_WIDTH  subordinate write data.
- sbr_rvalid_i  in  1  subordinate response valid.
- sbr_rready_o  out  1  subordinate response ready.
- sbr_rdata_i  in  DATA_WIDTH  subordinate response data.
- sbr_err_i  in  1  subordinate response error.

Behaviour:
- Reset: clock clk_i; reset reset_ni is asynchronous, active-low.
  - State returns to IDLE and owner to 0.
  - Priority pointer last_q resets to NUM_MGR-1, so manager 0 wins first.
  - With all mgr_req_i=0, every output is 0.
  - Reset mid-transaction abandons it; no response is delivered.
- States: IDLE, ADDR, RESP.
- IDLE:
  - Winner is the first requesting manager scanning last_q+1, last_q+2, ... with wrap modulo NUM_MGR.
  - If any request is present: sbr_req_o=1, the winner's addr/we/be/wdata are driven combinationally to the subordinate, and mgr_gnt_o[winner]=sbr_gnt_i.
  - If sbr_gnt_i=1: owner<=winner, last_q<=winner, go to RESP.
  - If sbr_gnt_i=0: owner<=winner, go to ADDR.
  - If there is no request, stay in IDLE and drive all sbr outputs to 0.
- ADDR (winner locked):
  - Drive owner's signals with sbr_req_o=1; mgr_gnt_o[owner]=sbr_gnt_i.
  - Higher-priority requests arriving now must not displace the owner.
  - On sbr_gnt_i: last_q<=owner, go to RESP.
  - If the owner drops mgr_req_i (protocol violation): sbr_req_o stays 1; behaviour is undefined but must not deadlock the FSM.
- RESP:
  - sbr_req_o=0 and all mgr_gnt_o=0.
  - mgr_rvalid_o[owner]=sbr_rvalid_i; all other rvalid bits are 0.
  - sbr_rready_o=mgr_rready_i[owner].
  - mgr_rdata_o=sbr_rdata_i and mgr_err_o=sbr_err_i, passed through combinationally.
  - On sbr_rvalid_i && mgr_rready_i[owner]: go to IDLE.
- Latency:
  - Grant is combinational in the same cycle as sbr_gnt_i; the arbiter adds no cycles.
  - Back-to-back transactions have at least one cycle between response handshake and next grant (the IDLE cycle).
- Fairness: with all managers requesting continuously, grants rotate 0,1,...,NUM_MGR-1,0. No manager waits more than NUM_MGR-1 transactions.
- Simultaneous events: the response handshake and a new request in the same cycle leave the new request pending until IDLE; it is not lost.
- Parameter check: a compile-time check rejects NUM_MGR<2 or NUM_MGR>8.

Test Plan:
- Single manager: reset, then mgr_req_i=01, we=1, addr=0x10, wdata=0xDEADBEEF, be=1111, with a subordinate granting immediately. Expect the write forwarded, mgr_gnt_o=01 the same cycle, then mgr_rvalid_o=01 with err=0.
- Contention: mgr_req_i=11 held for 4 transactions. Expect grant order 0,1,0,1 with rvalid routed only to the matching owner.
- Grant stall: subordinate withholds gnt 3 cycles while manager 0 requests; manager 1 raises req in cycle 2. Expect sbr_addr_o to stay manager 0's, and manager 1 to be served next.
- Response backpressure: read from addr 0x04 with rready=0 for 5 cycles. Expect mgr_rvalid_o[owner] held, sbr_rready_o=0, no new grant until rready=1.
- Error passthrough: subordinate returns err=1, rdata=0. Expect mgr_err_o=1 only during the owner's rvalid.
- Reset mid-RESP: assert reset_ni=0 while in RESP. Expect all outputs 0 immediately; after release, manager 0 has first priority.
